// File: rtl/compressor.sv
// Streaming AXI-Stream packet compressor: collapses runs of identical payload beats
// in IPv4/TCP TOS 0x28 packets into 32-bit run tokens; all other traffic passes verbatim.
module compressor #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_DATA   = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                wrt_en,
    input  logic [DATA_WIDTH*NUM_DATA-1:0]      data_in,
    input  logic                                tvalid_in,
    input  logic                                tlast_in,
    input  logic                                tready_in,
    output logic [DATA_WIDTH*NUM_DATA-1:0]      data_out,
    output logic                                tvalid_out,
    output logic                                tlast_out,
    output logic [DATA_WIDTH*NUM_DATA/8-1:0]    tkeep
);

    localparam int unsigned BEAT_W = DATA_WIDTH * NUM_DATA;
    localparam int unsigned KEEP_W = BEAT_W / 8;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned FILL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [KEEP_W-1:0] TOK_KEEP = KEEP_W'(4'hF);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef struct packed {
        logic              valid;
        logic              last;
        logic [KEEP_W-1:0] keep;
        logic [BEAT_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_PASS = 2'd1,
        ST_CMP  = 2'd2
    } state_t;

    // Input capture stage
    logic              in_v_q;
    logic              in_l_q;
    logic [BEAT_W-1:0] in_d_q;

    // Packet state
    state_t            st_q, st_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0] prev_q, prev_d;
    logic              have_prev_q, have_prev_d;

    // Output FIFO; entry 0 is the head and drives the outputs directly
    entry_t            ent_q [FIFO_DEPTH];
    entry_t            ent_d [FIFO_DEPTH];
    logic [FILL_W-1:0] fill_q, fill_d;

    entry_t            push0, push1;
    logic [1:0]        n_push;
    logic              pop;
    logic              commit;
    logic              hdr_match;
    logic [CNT_W-1:0]  cnt_inc;
    entry_t            beat_e;
    int                free_slots;

    function automatic entry_t make_token(input logic [CNT_W-1:0] n, input logic l);
        entry_t t;
        t       = '0;
        t.valid = 1'b1;
        t.last  = l;
        t.keep  = TOK_KEEP;
        t.data  = BEAT_W'(n);
        return t;
    endfunction

    assign data_out   = ent_q[0].data;
    assign tvalid_out = ent_q[0].valid;
    assign tlast_out  = ent_q[0].last;
    assign tkeep      = ent_q[0].keep;

    assign pop = ent_q[0].valid && tready_in;

    // Ethertype 0x0800, TOS 0x28, protocol TCP
    assign hdr_match = (in_d_q[103:96]  == 8'h08) &&
                       (in_d_q[111:104] == 8'h00) &&
                       (in_d_q[127:120] == 8'h28) &&
                       (in_d_q[191:184] == 8'h06);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_v_q <= 1'b0;
            in_l_q <= 1'b0;
            in_d_q <= '0;
        end else begin
            in_v_q <= tvalid_in && wrt_en;
            if (tvalid_in && wrt_en) begin
                in_l_q <= tlast_in;
                in_d_q <= data_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q        <= ST_HDR;
            cnt_q       <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            fill_q      <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            fill_q      <= fill_d;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // Packet FSM: decides what the captured beat turns into and whether it fits
    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        push0       = '0;
        push1       = '0;
        n_push      = 2'd0;
        cnt_inc     = cnt_q + CNT_W'(1);
        beat_e       = '0;
        beat_e.valid = 1'b1;
        beat_e.last  = in_l_q;
        beat_e.keep  = {KEEP_W{1'b1}};
        beat_e.data  = in_d_q;

        if (in_v_q) begin
            case (st_q)
                ST_HDR: begin
                    push0  = beat_e;
                    n_push = 2'd1;
                    if (!in_l_q) begin
                        st_d = hdr_match ? ST_CMP : ST_PASS;
                    end
                end
                ST_PASS: begin
                    push0  = beat_e;
                    n_push = 2'd1;
                    if (in_l_q) begin
                        st_d = ST_HDR;
                    end
                end
                ST_CMP: begin
                    if (!have_prev_q) begin
                        push0       = beat_e;
                        n_push      = 2'd1;
                        prev_d      = in_d_q;
                        have_prev_d = 1'b1;
                    end else if (in_d_q == prev_q) begin
                        // Flush on packet end or when the count saturates
                        if (in_l_q || cnt_inc == CNT_MAX) begin
                            push0  = make_token(cnt_inc, in_l_q);
                            n_push = 2'd1;
                            cnt_d  = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        prev_d = in_d_q;
                        cnt_d  = '0;
                        if (cnt_q != '0) begin
                            push0  = make_token(cnt_q, 1'b0);
                            push1  = beat_e;
                            n_push = 2'd2;
                        end else begin
                            push0  = beat_e;
                            n_push = 2'd1;
                        end
                    end
                    if (in_l_q) begin
                        st_d        = ST_HDR;
                        cnt_d       = '0;
                        prev_d      = '0;
                        have_prev_d = 1'b0;
                    end
                end
                default: st_d = ST_HDR;
            endcase
        end

        free_slots = int'(FIFO_DEPTH) - int'(fill_q) + int'(pop);
        commit     = in_v_q && (int'(n_push) <= free_slots);

        // A beat that does not fit is dropped without touching any state
        if (!commit) begin
            st_d        = st_q;
            cnt_d       = cnt_q;
            prev_d      = prev_q;
            have_prev_d = have_prev_q;
            n_push      = 2'd0;
        end
    end

    // Shift-down FIFO: unused slots stay zero so an empty head reads as all zeros
    always_comb begin
        int base;
        ent_d = ent_q;
        base  = int'(fill_q);
        if (pop) begin
            for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
                ent_d[i] = ent_q[i+1];
            end
            ent_d[FIFO_DEPTH-1] = '0;
            base = base - 1;
        end
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (n_push != 2'd0 && i == base) begin
                ent_d[i] = push0;
            end
            if (n_push == 2'd2 && i == base + 1) begin
                ent_d[i] = push1;
            end
        end
        fill_d = FILL_W'(int'(fill_q) - int'(pop) + int'(n_push));
    end

endmodule

// File: tb/tb_compressor.sv
// Directed self-checking bench for compressor: hand-built packets, expected output
// streams written out by hand and compared beat by beat.
module tb_compressor;

    logic         clk = 1'b0;
    logic         reset;
    logic         wrt_en;
    logic [255:0] data_in;
    logic         tvalid_in;
    logic         tlast_in;
    logic         tready_in;
    logic [255:0] data_out;
    logic         tvalid_out;
    logic         tlast_out;
    logic [31:0]  tkeep;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
    } obs_t;

    obs_t got_q[$];
    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    compressor dut (
        .clk        (clk),
        .reset      (reset),
        .wrt_en     (wrt_en),
        .data_in    (data_in),
        .tvalid_in  (tvalid_in),
        .tlast_in   (tlast_in),
        .tready_in  (tready_in),
        .data_out   (data_out),
        .tvalid_out (tvalid_out),
        .tlast_out  (tlast_out),
        .tkeep      (tkeep)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so negedge sees what the next edge transfers
    always @(negedge clk) begin
        if (!reset && tvalid_out && tready_in) begin
            got_q.push_back({data_out, tkeep, tlast_out});
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [255:0] d, input logic l);
        data_in   = d;
        tlast_in  = l;
        tvalid_in = 1'b1;
        tick();
        tvalid_in = 1'b0;
        tlast_in  = 1'b0;
    endtask

    task automatic exp_beat(input logic [255:0] d, input logic l);
        obs_t e;
        e.data = d;
        e.keep = 32'hFFFF_FFFF;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic exp_tok(input logic [31:0] n, input logic l);
        obs_t e;
        e.data = 256'(n);
        e.keep = 32'h0000_000F;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        repeat (3) tick();
        for (int i = 0; i < 60 && tvalid_out === 1'b1; i++) tick();
        check("drain_timeout", 256'(tvalid_out), 256'(0));
    endtask

    task automatic compare(input string name);
        int n;
        check({name, ".count"}, 256'(got_q.size()), 256'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d].data", name, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s[%0d].keep", name, i), 256'(got_q[i].keep), 256'(exp_q[i].keep));
            check($sformatf("%s[%0d].last", name, i), 256'(got_q[i].last), 256'(exp_q[i].last));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [255:0] mk_hdr(input logic [7:0] tos, input logic [7:0] proto);
        logic [255:0] h;
        h          = {8{32'h0102_0304}};
        h[103:96]  = 8'h08;
        h[111:104] = 8'h00;
        h[127:120] = tos;
        h[135:128] = 8'h05;
        h[143:136] = 8'hDC;
        h[191:184] = proto;
        return h;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] ff, xb, mx, h_pass, h_tos, h_cmp, a_b, b_b, c_b, d_b;
        ff      = '1;
        xb      = '1;
        xb[255:240] = 16'h85AB;
        mx      = {8{32'hA5A5_0F0F}};
        a_b     = {8{32'h1111_1111}};
        b_b     = {8{32'h2222_2222}};
        c_b     = {8{32'h3333_3333}};
        d_b     = {8{32'h4444_4444}};
        h_pass  = mk_hdr(8'h28, 8'h05);
        h_tos   = mk_hdr(8'h27, 8'h06);
        h_cmp   = mk_hdr(8'h28, 8'h06);

        reset = 1'b1; wrt_en = 1'b1; tvalid_in = 1'b0; tlast_in = 1'b0;
        tready_in = 1'b1; data_in = '0;
        tick(); tick();
        check("rst_valid", 256'(tvalid_out), 256'(0));
        check("rst_data", data_out, 256'(0));
        check("rst_keep", 256'(tkeep), 256'(0));
        check("rst_last", 256'(tlast_out), 256'(0));
        reset = 1'b0;
        tick();

        // Protocol mismatch passes through; also checks one-cycle output latency
        send(h_pass, 1'b0);
        check("lat_early", 256'(tvalid_out), 256'(0));
        tick();
        check("lat_valid", 256'(tvalid_out), 256'(1));
        check("lat_data", data_out, h_pass);
        send(ff, 1'b1);
        exp_beat(h_pass, 1'b0); exp_beat(ff, 1'b1);
        drain();
        compare("proto");

        // TOS mismatch: repeated beats are not suppressed
        send(h_tos, 1'b0);
        repeat (4) send(ff, 1'b0);
        send(mx, 1'b1);
        exp_beat(h_tos, 1'b0);
        repeat (4) exp_beat(ff, 1'b0);
        exp_beat(mx, 1'b1);
        drain();
        compare("tos");

        // Long run ending on a suppressed tlast beat
        send(h_cmp, 1'b0);
        repeat (40) send(ff, 1'b0);
        send(ff, 1'b1);
        exp_beat(h_cmp, 1'b0); exp_beat(ff, 1'b0); exp_tok(32'd40, 1'b1);
        drain();
        compare("run40");

        // Run broken by a differing beat, then a short run at packet end
        send(h_cmp, 1'b0);
        repeat (3) send(ff, 1'b0);
        send(xb, 1'b0);
        send(xb, 1'b1);
        exp_beat(h_cmp, 1'b0); exp_beat(ff, 1'b0); exp_tok(32'd2, 1'b0);
        exp_beat(xb, 1'b0); exp_tok(32'd1, 1'b1);
        drain();
        compare("break");

        // Backpressure for three cycles mid-packet
        send(h_cmp, 1'b0);
        tready_in = 1'b0;
        send(a_b, 1'b0);
        check("bp_hold_data0", data_out, h_cmp);
        send(b_b, 1'b0);
        send(c_b, 1'b0);
        check("bp_hold_data3", data_out, h_cmp);
        check("bp_hold_valid", 256'(tvalid_out), 256'(1));
        check("bp_hold_last", 256'(tlast_out), 256'(0));
        tready_in = 1'b1;
        send(d_b, 1'b1);
        exp_beat(h_cmp, 1'b0); exp_beat(a_b, 1'b0); exp_beat(b_b, 1'b0);
        exp_beat(c_b, 1'b0); exp_beat(d_b, 1'b1);
        drain();
        compare("bp");

        // Reset mid-packet clears outputs at once; next beat is a header again
        tready_in = 1'b0;
        send(h_cmp, 1'b0);
        send(ff, 1'b0);
        send(ff, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        check("mrst_valid", 256'(tvalid_out), 256'(0));
        check("mrst_data", data_out, 256'(0));
        check("mrst_keep", 256'(tkeep), 256'(0));
        check("mrst_last", 256'(tlast_out), 256'(0));
        tick();
        reset = 1'b0;
        tready_in = 1'b1;
        got_q.delete();
        exp_q.delete();
        tick();
        send(h_pass, 1'b0);
        send(ff, 1'b1);
        exp_beat(h_pass, 1'b0); exp_beat(ff, 1'b1);
        drain();
        compare("mrst");

        // wrt_en low: valid beats ignored, packet state kept
        send(h_cmp, 1'b0);
        send(ff, 1'b0);
        wrt_en = 1'b0;
        data_in = ff; tlast_in = 1'b1; tvalid_in = 1'b1;
        repeat (3) tick();
        tvalid_in = 1'b0; tlast_in = 1'b0;
        wrt_en = 1'b1;
        send(xb, 1'b1);
        exp_beat(h_cmp, 1'b0); exp_beat(ff, 1'b0); exp_beat(xb, 1'b1);
        drain();
        compare("wrten");

        // Overflow: fifth beat into a full FIFO with no pop is dropped
        tready_in = 1'b0;
        send(h_pass, 1'b0);
        send(a_b, 1'b0);
        send(b_b, 1'b0);
        send(c_b, 1'b0);
        send(d_b, 1'b1);
        tick();
        tready_in = 1'b1;
        exp_beat(h_pass, 1'b0); exp_beat(a_b, 1'b0);
        exp_beat(b_b, 1'b0); exp_beat(c_b, 1'b0);
        drain();
        compare("ovf");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/compressor.md
Name: compressor

Overview:
- Streaming 256-bit AXI-Stream packet compressor sitting between the Ethernet RX datapath and the downstream DMA/stream consumer.
- The first beat of each packet is classified as IPv4/TCP with DSCP/TOS 0x28. Matching packets have runs of identical consecutive payload beats replaced by short run tokens.
- All other packets pass through unchanged.

Parameters:
- DATA_WIDTH, 32, bits per data word.
- NUM_DATA, 8, words per beat; beat = DATA_WIDTH*NUM_DATA = 256 bits, 32 bytes.
- FIFO_DEPTH, 4, entries in the output FIFO.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wrt_en  in  1  input qualifier; a beat is accepted only when tvalid_in && wrt_en.
- data_in  in  256  input beat; byte n = data_in[8n+7:8n]. Input beats are always fully populated.
- tvalid_in  in  1  input beat valid.
- tlast_in  in  1  last beat of the input packet.
- tready_in  in  1  downstream ready for the output stream.
- data_out  out  256  output beat.
- tvalid_out  out  1  output beat valid.
- tlast_out  out  1  last beat of the output packet.
- tkeep  out  32  byte-valid mask for data_out (bit n covers byte n).

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Asserting reset clears data_out, tvalid_out, tlast_out, tkeep, the FIFO, the run counter, the previous-beat register and the packet state. The block waits for the first beat of a packet. A packet in flight when reset is asserted is discarded.
- Packet state: the first accepted beat after reset, or after a beat with tlast_in set, is the header beat.
- Classification of the header beat: it matches when all of the following hold:
  - byte12 = 0x08 and byte13 = 0x00 (ethertype 0x0800);
  - byte15 = 0x28 (TOS);
  - byte23 = 0x06 (protocol TCP).
  - Other bytes, including total length in bytes 16-17, are ignored.
- The header beat is always emitted unchanged with tkeep = 32'hFFFFFFFF.
- Non-matching packets: every beat is emitted unchanged with tkeep all ones; tlast_out = tlast_in.
- Matching packets, payload beats (index >= 1): each beat is compared with the previous payload beat.
  - No previous beat exists for the first payload beat, so it is always emitted.
  - An equal beat is suppressed and a 32-bit run counter is incremented.
  - When a differing beat arrives and the counter is nonzero, emit a run token, then the new beat; the counter clears to 0.
- Run token format: data_out[31:0] = count (number of suppressed beats), all other bits 0, tkeep = 32'h0000000F.
  - Input beats are always full, so any output beat with tkeep != all ones is a token.
- Packet end for a matching packet:
  - If the tlast beat is suppressed, the token is emitted with tlast_out = 1.
  - If the tlast beat differs, the pending token (if any) is emitted with tlast_out = 0, then the tlast beat with tlast_out = 1.
  - The counter and previous-beat register clear at packet end.
- Counter saturation: on reaching 32'hFFFFFFFF, emit a token and restart the count at 0. The previous beat is kept.
- Single-beat packets (tlast_in on the header beat) pass through unchanged.
- Latency: with the FIFO empty and tready_in high, a beat accepted at edge n is presented on the outputs after edge n+1.
  - A token occupies the slot of the run-breaking beat; that beat follows one cycle later.
- Output handshake:
  - Outputs pop from a FIFO_DEPTH-deep FIFO.
  - A transfer occurs when tvalid_out && tready_in.
  - While tready_in is low, data_out, tkeep, tlast_out and tvalid_out hold.
  - When the FIFO is empty: tvalid_out = 0, data_out = 0, tkeep = 0, tlast_out = 0.
- Overflow: there is no upstream ready. A beat accepted while the FIFO cannot take all entries it generates is dropped entirely, and no other state changes.
  - With tready_in continuously high, overflow cannot occur: a token plus a beat is always preceded by at least one suppressed cycle.
- Simultaneous push and pop in the same cycle are allowed, including when the FIFO is full.

Test Plan:
- Pass-through, protocol mismatch: header with byte12 = 08, byte15 = 28, byte23 = 05, bytes 16-17 = 05 DC, then an all-FF beat with tlast -> both beats output unchanged, tkeep = FFFFFFFF, tlast_out on the second.
- TOS mismatch: header with byte15 = 27, byte23 = 06, then 4 all-FF beats, then a mixed beat with tlast -> all 6 beats output verbatim, none suppressed.
- Compression: header with byte15 = 28, byte23 = 06, then 40 all-FF beats, then tlast on a final all-FF beat -> header, one FF beat, then a token with data_out[31:0] = 40, tkeep = 0000000F and tlast_out = 1.
- Run break: matching header, FF, FF, FF, X (= 85AB…FFFF), X with tlast -> header, FF, token(2), X, token(1) with tlast_out = 1.
- Backpressure and reset: drop tready_in for 3 cycles mid-packet -> outputs hold stable and no beat is lost or duplicated. Assert reset mid-packet -> outputs go to 0 immediately, and the next beat is classified as a header.
- wrt_en = 0 with tvalid_in = 1 -> no beats accepted, no outputs, and packet state unchanged.
